// File: rtl/ad7606_pkg.sv
// Shared types and constants for the AD7606 frame packer.
// FRAME_SEQ_EN adds a sequence state and lengthens the frame by one byte.
package ad7606_pkg;

  typedef logic [7:0][15:0] ch_data_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR0,
    ST_HDR1,
`ifdef FRAME_SEQ_EN
    ST_SEQ,
`endif
    ST_DATA,
    ST_CKSUM
  } pack_state_t;

  localparam int FRAME_PAYLOAD_BYTES = 16;
`ifdef FRAME_SEQ_EN
  localparam int FRAME_LEN = 20;
`else
  localparam int FRAME_LEN = 19;
`endif

  localparam logic [15:0] DEFAULT_HEADER = 16'hA55A;

  // Payload byte idx: channel idx/2, high byte on even idx.
  function automatic logic [7:0] payload_byte(input ch_data_t d, input logic [3:0] idx);
    return idx[0] ? d[idx[3:1]][7:0] : d[idx[3:1]][15:8];
  endfunction

endpackage

// File: rtl/freq_tick_gen.sv
// Free-running divider producing a one-cycle tick every CLK_FRE MHz / SEND_FRE Hz cycles.
// Shared with the UART top; no configuration macros.
module freq_tick_gen #(
  parameter int CLK_FRE  = 50,
  parameter int SEND_FRE = 2
) (
  input  logic clk,
  input  logic rst,
  output logic tick_o
);

  localparam int TICK_DIV = CLK_FRE * 1_000_000 / SEND_FRE;
  localparam int CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] TC = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  assign tick_o = (cnt_q == TC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (tick_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ad7606_frame_packer.sv
// Snapshots one 8-channel AD7606 result per send tick and streams it as a header/payload/checksum
// byte frame on a valid/ready interface. Define FRAME_SEQ_EN to insert a rolling sequence byte.
module ad7606_frame_packer
  import ad7606_pkg::*;
#(
  parameter int          CLK_FRE  = 50,
  parameter int          SEND_FRE = 2,
  parameter logic [15:0] HEADER   = DEFAULT_HEADER
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_valid,
  input  logic [7:0][15:0] sample_data,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             frame_busy,
  output logic             frame_drop
);

  // state    | meaning
  // IDLE     | waiting for a pending tick and a fresh sample
  // HDR0     | header high byte on the bus
  // HDR1     | header low byte on the bus
  // SEQ      | sequence byte on the bus (FRAME_SEQ_EN only)
  // DATA     | payload byte idx_q on the bus
  // CKSUM    | checksum byte on the bus

  logic        tick;
  pack_state_t state_q;
  ch_data_t    snap_q;
  logic [3:0]  idx_q;
  logic [7:0]  cksum_q;
  logic        pending_q;
  logic [7:0]  tx_data_q;
  logic        tx_valid_q;
  logic        drop_q;
`ifdef FRAME_SEQ_EN
  logic [7:0]  seq_q;
`endif

  freq_tick_gen #(
    .CLK_FRE (CLK_FRE),
    .SEND_FRE(SEND_FRE)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .tick_o(tick)
  );

  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign frame_drop = drop_q;
  assign frame_busy = (state_q != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      snap_q     <= '0;
      idx_q      <= '0;
      cksum_q    <= '0;
      pending_q  <= 1'b0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      drop_q     <= 1'b0;
`ifdef FRAME_SEQ_EN
      seq_q      <= '0;
`endif
    end else begin
      drop_q <= tick && (pending_q || (state_q != ST_IDLE));

      case (state_q)
        ST_IDLE: begin
          if (pending_q && sample_valid) begin
            snap_q     <= sample_data;
            pending_q  <= 1'b0;
            idx_q      <= '0;
            cksum_q    <= '0;
            tx_data_q  <= HEADER[15:8];
            tx_valid_q <= 1'b1;
            state_q    <= ST_HDR0;
          end else if (tick) begin
            pending_q <= 1'b1;
          end
        end

        default: begin
          if (tx_ready) begin
            case (state_q)
              ST_HDR0: begin
                tx_data_q <= HEADER[7:0];
                state_q   <= ST_HDR1;
              end
              ST_HDR1: begin
`ifdef FRAME_SEQ_EN
                tx_data_q <= seq_q;
                state_q   <= ST_SEQ;
`else
                tx_data_q <= payload_byte(snap_q, 4'd0);
                state_q   <= ST_DATA;
`endif
              end
`ifdef FRAME_SEQ_EN
              ST_SEQ: begin
                cksum_q   <= cksum_q + tx_data_q;
                tx_data_q <= payload_byte(snap_q, 4'd0);
                state_q   <= ST_DATA;
              end
`endif
              ST_DATA: begin
                // Running sum covers every byte already sent; fold in the one leaving now.
                cksum_q <= cksum_q + tx_data_q;
                if (idx_q == 4'(FRAME_PAYLOAD_BYTES - 1)) begin
                  tx_data_q <= cksum_q + tx_data_q;
                  state_q   <= ST_CKSUM;
                end else begin
                  idx_q     <= idx_q + 4'd1;
                  tx_data_q <= payload_byte(snap_q, idx_q + 4'd1);
                end
              end
              ST_CKSUM: begin
                tx_valid_q <= 1'b0;
                state_q    <= ST_IDLE;
`ifdef FRAME_SEQ_EN
                seq_q      <= seq_q + 8'd1;
`endif
              end
              default: begin
                state_q <= ST_IDLE;
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ad7606_frame_packer.sv
// Randomised bench for ad7606_frame_packer against a queue-based frame model.
// Honours FRAME_SEQ_EN the same way as the design.
module tb_ad7606_frame_packer;
  import ad7606_pkg::*;

  localparam int CLK_FRE  = 1;
  localparam int SEND_FRE = 100000;
  localparam int DIV      = CLK_FRE * 1_000_000 / SEND_FRE;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             sample_valid = 1'b0;
  logic [7:0][15:0] sample_data = '0;
  logic             tx_ready = 1'b0;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             frame_busy;
  logic             frame_drop;

  ad7606_frame_packer #(
    .CLK_FRE (CLK_FRE),
    .SEND_FRE(SEND_FRE),
    .HEADER  (16'hA55A)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sample_valid(sample_valid),
    .sample_data (sample_data),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .frame_busy  (frame_busy),
    .frame_drop  (frame_drop)
  );

  always #5 clk = ~clk;

  // Reference model: bytes still owed for the current frame, plus tick/pending bookkeeping.
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  bit          m_pend;
  int          m_cnt;
  bit          m_drop;
  logic [7:0]  m_seq;
  logic [10:0] m_exp;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void model_reset();
    exp_q.delete();
    got_q.delete();
    m_pend = 1'b0;
    m_cnt  = 0;
    m_drop = 1'b0;
    m_seq  = 8'h00;
    m_exp  = '0;
  endfunction

  function automatic void push_frame(input logic [7:0][15:0] d);
    int sum;
    sum = 0;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
`ifdef FRAME_SEQ_EN
    exp_q.push_back(m_seq);
    sum += int'(m_seq);
`endif
    for (int c = 0; c < 8; c++) begin
      exp_q.push_back(d[c][15:8]);
      exp_q.push_back(d[c][7:0]);
      sum += int'(d[c][15:8]) + int'(d[c][7:0]);
    end
    exp_q.push_back(8'(sum % 256));
  endfunction

  function automatic logic [7:0][15:0] rand_data();
    logic [7:0][15:0] d;
    for (int c = 0; c < 8; c++) d[c] = 16'($urandom);
    return d;
  endfunction

  // Advance one clock: record any accepted byte, update the model, wait for the next negedge.
  task automatic step();
    bit tick, busy, cap, ev;
    logic [7:0] tmp;
    if (tx_valid && tx_ready) got_q.push_back(tx_data);
    busy   = (exp_q.size() != 0);
    tick   = (m_cnt == DIV - 1);
    m_cnt  = tick ? 0 : m_cnt + 1;
    m_drop = tick && (m_pend || busy);
    cap    = !busy && m_pend && sample_valid;
    if (busy && tx_ready) begin
      tmp = exp_q.pop_front();
      if (exp_q.size() == 0) m_seq = m_seq + 8'd1;
    end
    if (cap) begin
      push_frame(sample_data);
      m_pend = 1'b0;
    end else if (tick && !busy) begin
      m_pend = 1'b1;
    end
    ev    = (exp_q.size() != 0);
    m_exp = {ev, ev ? exp_q[0] : 8'h00, ev, m_drop};
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    sample_valid = 1'b0;
    tx_ready     = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
    n_checks++;
    if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    n_checks++;
    if (frame_busy !== 1'b0) begin n_fail++; $display("FAIL reset_frame_busy: got %b want 0", frame_busy); end
    n_checks++;
    if (frame_drop !== 1'b0) begin n_fail++; $display("FAIL reset_frame_drop: got %b want 0", frame_drop); end
    do_reset();
  endtask

  task automatic test_basic_frame();
    logic [7:0] gold[$];
    do_reset();
    sample_data    = '0;
    sample_data[0] = 16'h1234;
    tx_ready       = 1'b1;
    for (int i = 0; i < 80; i++) begin
      sample_valid = (i % 3 == 0);
      step();
      n_checks++;
      if ({tx_valid, tx_valid ? tx_data : 8'h00, frame_busy, frame_drop} !== m_exp) begin
        n_fail++;
        $display("FAIL basic cyc %0d: got v/d/busy/drop %b/%h/%b/%b want %b/%h/%b/%b", i,
                 tx_valid, tx_data, frame_busy, frame_drop, m_exp[10], m_exp[9:2], m_exp[1], m_exp[0]);
      end
    end
    gold = '{8'hA5, 8'h5A};
`ifdef FRAME_SEQ_EN
    gold.push_back(8'h00);
`endif
    gold.push_back(8'h12);
    gold.push_back(8'h34);
    repeat (14) gold.push_back(8'h00);
    gold.push_back(8'h46);
    n_checks++;
    if (got_q.size() < gold.size()) begin
      n_fail++;
      $display("FAIL basic_len: got %0d bytes want at least %0d", got_q.size(), gold.size());
    end else begin
      for (int k = 0; k < gold.size(); k++) begin
        n_checks++;
        if (got_q[k] !== gold[k]) begin
          n_fail++;
          $display("FAIL basic_byte %0d: got %h want %h", k, got_q[k], gold[k]);
        end
      end
    end
  endtask

  task automatic test_all_ones();
    int ff_cnt;
    do_reset();
    for (int c = 0; c < 8; c++) sample_data[c] = 16'hFFFF;
    tx_ready     = 1'b1;
    sample_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      n_checks++;
      if ({tx_valid, tx_valid ? tx_data : 8'h00, frame_busy, frame_drop} !== m_exp) begin
        n_fail++;
        $display("FAIL all_ones cyc %0d: got v/d/busy/drop %b/%h/%b/%b want %b/%h/%b/%b", i,
                 tx_valid, tx_data, frame_busy, frame_drop, m_exp[10], m_exp[9:2], m_exp[1], m_exp[0]);
      end
    end
    n_checks++;
    if (got_q.size() < FRAME_LEN) begin
      n_fail++;
      $display("FAIL all_ones_len: got %0d bytes want %0d", got_q.size(), FRAME_LEN);
    end else begin
      ff_cnt = 0;
      for (int k = FRAME_LEN - 17; k < FRAME_LEN - 1; k++) if (got_q[k] === 8'hFF) ff_cnt++;
      n_checks++;
      if (ff_cnt != 16) begin n_fail++; $display("FAIL all_ones_payload: got %0d FF bytes want 16", ff_cnt); end
      n_checks++;
      if (got_q[FRAME_LEN-1] !== 8'hF0) begin
        n_fail++;
        $display("FAIL all_ones_cksum: got %h want f0", got_q[FRAME_LEN-1]);
      end
    end
  endtask

  task automatic test_stall_toggle();
    do_reset();
    for (int i = 0; i < 120; i++) begin
      tx_ready     = i[0];
      sample_valid = ($urandom_range(0, 1) == 1);
      sample_data  = rand_data();
      step();
      n_checks++;
      if ({tx_valid, tx_valid ? tx_data : 8'h00, frame_busy, frame_drop} !== m_exp) begin
        n_fail++;
        $display("FAIL stall_toggle cyc %0d: got v/d/busy/drop %b/%h/%b/%b want %b/%h/%b/%b", i,
                 tx_valid, tx_data, frame_busy, frame_drop, m_exp[10], m_exp[9:2], m_exp[1], m_exp[0]);
      end
    end
  endtask

  task automatic test_ready_low();
    int drops;
    do_reset();
    sample_data  = rand_data();
    sample_valid = 1'b1;
    tx_ready     = 1'b0;
    drops        = 0;
    for (int i = 0; i < 65; i++) begin
      if (i == 35) begin
        tx_ready     = 1'b1;
        sample_valid = 1'b0;
      end
      step();
      if (i < 35 && frame_drop) drops++;
      n_checks++;
      if ({tx_valid, tx_valid ? tx_data : 8'h00, frame_busy, frame_drop} !== m_exp) begin
        n_fail++;
        $display("FAIL ready_low cyc %0d: got v/d/busy/drop %b/%h/%b/%b want %b/%h/%b/%b", i,
                 tx_valid, tx_data, frame_busy, frame_drop, m_exp[10], m_exp[9:2], m_exp[1], m_exp[0]);
      end
    end
    n_checks++;
    if (drops != 2) begin n_fail++; $display("FAIL ready_low_drops: got %0d want 2", drops); end
    n_checks++;
    if (got_q.size() != FRAME_LEN) begin
      n_fail++;
      $display("FAIL ready_low_frames: got %0d bytes want %0d", got_q.size(), FRAME_LEN);
    end
  endtask

  task automatic test_no_sample();
    int drops;
    do_reset();
    sample_data  = rand_data();
    sample_valid = 1'b0;
    tx_ready     = 1'b1;
    drops        = 0;
    for (int i = 0; i < 66; i++) begin
      sample_valid = (i == 40);
      step();
      if (i < 40 && frame_drop) drops++;
      n_checks++;
      if ({tx_valid, tx_valid ? tx_data : 8'h00, frame_busy, frame_drop} !== m_exp) begin
        n_fail++;
        $display("FAIL no_sample cyc %0d: got v/d/busy/drop %b/%h/%b/%b want %b/%h/%b/%b", i,
                 tx_valid, tx_data, frame_busy, frame_drop, m_exp[10], m_exp[9:2], m_exp[1], m_exp[0]);
      end
    end
    n_checks++;
    if (drops != 3) begin n_fail++; $display("FAIL no_sample_drops: got %0d want 3", drops); end
    n_checks++;
    if (got_q.size() != FRAME_LEN) begin
      n_fail++;
      $display("FAIL no_sample_frame: got %0d bytes want %0d", got_q.size(), FRAME_LEN);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      sample_valid = ($urandom_range(0, 3) == 0);
      tx_ready     = ($urandom_range(0, 3) != 0);
      sample_data  = rand_data();
      step();
      n_checks++;
      if ({tx_valid, tx_valid ? tx_data : 8'h00, frame_busy, frame_drop} !== m_exp) begin
        n_fail++;
        $display("FAIL random cyc %0d: got v/d/busy/drop %b/%h/%b/%b want %b/%h/%b/%b", i,
                 tx_valid, tx_data, frame_busy, frame_drop, m_exp[10], m_exp[9:2], m_exp[1], m_exp[0]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int guard;
    do_reset();
    sample_data  = rand_data();
    sample_valid = 1'b1;
    tx_ready     = 1'b1;
    guard        = 0;
    while (got_q.size() < 7 && guard < 200) begin
      step();
      guard++;
    end
    n_checks++;
    if (got_q.size() < 7) begin
      n_fail++;
      $display("FAIL mid_reset_reach: got %0d bytes want 7 within 200 cycles", got_q.size());
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_tx_valid: got %b want 0", tx_valid); end
    n_checks++;
    if (frame_busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset_busy: got %b want 0", frame_busy); end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      n_checks++;
      if ({tx_valid, tx_valid ? tx_data : 8'h00, frame_busy, frame_drop} !== m_exp) begin
        n_fail++;
        $display("FAIL mid_reset cyc %0d: got v/d/busy/drop %b/%h/%b/%b want %b/%h/%b/%b", i,
                 tx_valid, tx_data, frame_busy, frame_drop, m_exp[10], m_exp[9:2], m_exp[1], m_exp[0]);
      end
    end
    n_checks++;
    if (got_q.size() == 0 || got_q[0] !== 8'hA5) begin
      n_fail++;
      $display("FAIL mid_reset_restart: got %0d bytes, first %h, want first a5", got_q.size(),
               got_q.size() == 0 ? 8'h00 : got_q[0]);
    end
  endtask

`ifdef FRAME_SEQ_EN
  task automatic test_seq_wrap();
    do_reset();
    sample_valid = 1'b1;
    tx_ready     = 1'b1;
    for (int i = 0; i < 258 * 30 + 40; i++) begin
      sample_data = rand_data();
      step();
      n_checks++;
      if ({tx_valid, tx_valid ? tx_data : 8'h00, frame_busy, frame_drop} !== m_exp) begin
        n_fail++;
        $display("FAIL seq_wrap cyc %0d: got v/d/busy/drop %b/%h/%b/%b want %b/%h/%b/%b", i,
                 tx_valid, tx_data, frame_busy, frame_drop, m_exp[10], m_exp[9:2], m_exp[1], m_exp[0]);
      end
    end
  endtask
`endif

  initial begin
    #900_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_basic_frame();
    test_all_ones();
    test_stall_toggle();
    test_ready_low();
    test_no_sample();
    test_random();
    test_reset_mid_frame();
`ifdef FRAME_SEQ_EN
    test_seq_wrap();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
